risc_state_dump: RTL and testbench
==================================

// Module: risc_state_dump
// PURPOSE
//  Debug readout engine for iitb_risc: on request, stalls the core, reads the
//  register file and a window of data memory, and streams every word out over
//  a valid/ready port. It reads back the state that bench/loader logic
//  preloads, so final R0-R7/data_mem checks need no hierarchical peeks.
// PARAMETERS
//  NUM_REGS   8      registers dumped, index 0..NUM_REGS-1 (max 8)
//  MEM_BASE   16'd0  first data-memory word address dumped
//  MEM_WORDS  16     data-memory words dumped (0 = skip memory phase)
//  DATA_W     16     word width
//  ADDR_W     16     data-memory address width
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       synchronous, active-high
//  start       in   1       begin dump; sampled only in IDLE
//  halt_req    out  1       stall request to core pipeline
//  halt_ack    in   1       core drained and frozen
//  rf_rd_addr  out  3       register-file read index
//  rf_rd_data  in   DATA_W  register-file data, combinational from rf_rd_addr
//  dm_rd_en    out  1       data-memory read strobe
//  dm_rd_addr  out  ADDR_W  data-memory read address
//  dm_rd_data  in   DATA_W  valid the cycle after dm_rd_en
//  out_valid   out  1       stream word valid
//  out_ready   in   1       sink accepts word
//  out_data    out  DATA_W  dumped word
//  out_is_mem  out  1       0 = register word, 1 = memory word
//  out_index   out  ADDR_W  register number or memory address of out_data
//  out_last    out  1       final word of dump
//  busy        out  1       high in every state except IDLE
//  done        out  1       one-cycle pulse when dump completes
// BEHAVIOUR
//  Reset: state IDLE; halt_req, dm_rd_en, out_valid, out_last, busy, done = 0;
//   out_data, out_index, rf_rd_addr, dm_rd_addr = 0.
//  FSM:
//   IDLE   : start=1 -> HALT. start in any other state ignored.
//   HALT   : halt_req=1; wait halt_ack=1 -> RF_LD (idx=0).
//   RF_LD  : rf_rd_addr=idx; capture rf_rd_data into out_data,
//            out_index=idx, out_is_mem=0 -> RF_OUT.
//   RF_OUT : out_valid=1; on out_ready: idx<NUM_REGS-1 -> RF_LD(idx+1);
//            else MEM_WORDS>0 -> DM_REQ(ptr=MEM_BASE, cnt=0); else -> DONE.
//   DM_REQ : dm_rd_en=1 for exactly 1 cycle, dm_rd_addr=ptr -> DM_LD.
//   DM_LD  : capture dm_rd_data, out_index=ptr, out_is_mem=1 -> DM_OUT.
//   DM_OUT : out_valid=1; on out_ready: cnt<MEM_WORDS-1 -> DM_REQ
//            (ptr+1, cnt+1); else -> DONE.
//   DONE   : done=1 one cycle, halt_req drops same cycle -> IDLE.
//  halt_req stays high from HALT through the last accepted word; deassertion of
//   halt_ack after entry to RF_LD is ignored.
//  Handshake: transfer when out_valid&&out_ready at a rising edge. While
//   out_valid=1 and out_ready=0, out_data/out_index/out_is_mem/out_last hold
//   stable. out_valid never drops without a transfer (except on reset).
//  out_last=1 only with the final word: last memory word, or last register
//   when MEM_WORDS=0.
//  Latency: start->halt_req 1 cycle; halt_ack->first out_valid 2 cycles;
//   with out_ready tied high, 2 cycles/reg word, 3 cycles/mem word;
//   final transfer->done 1 cycle.
//  Address arithmetic: ptr increments modulo 2^ADDR_W (MEM_BASE+k wraps to 0).
//  Reset mid-dump: IDLE next edge; halt_req, out_valid drop; no done pulse.
// TESTING
//  1 Regs R2=2,R3=3,R4=4, others 0, MEM_WORDS=0, out_ready=1, halt_ack=1 ->
//    8 words idx0..7 = 0,0,2,3,4,0,0,0; out_last on idx7; done 1 cycle later.
//  2 MEM_BASE=10, MEM_WORDS=2, mem[10]=16'h0000, mem[11]=16'h00AB ->
//    after 8 reg words: (mem,10,0000),(mem,11,00AB,last); one dm_rd_en per word.
//  3 out_ready low 5 cycles mid-register phase -> word held stable, no loss or
//    duplication; total words still 8+MEM_WORDS.
//  4 halt_ack delayed 6 cycles after start -> no out_valid/rf reads before ack;
//    start pulses during busy ignored (exactly one dump).
//  5 MEM_BASE=16'hFFFF, MEM_WORDS=2 -> memory indices FFFF then 0000.
//  6 reset asserted during DM_OUT -> next cycle busy=0, halt_req=0,
//    out_valid=0, no done; fresh start gives complete dump.

Source files
------------

// File: rtl/risc_state_dump.sv
// Debug readout engine: stalls the core, walks the register file and a window
// of data memory, and streams every word out over a valid/ready port.
module risc_state_dump #(
  parameter int              NUM_REGS  = 8,
  parameter int              DATA_W    = 16,
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] MEM_BASE = '0,
  parameter int              MEM_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [2:0]        rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              dm_rd_en,
  output logic [ADDR_W-1:0] dm_rd_addr,
  input  logic [DATA_W-1:0] dm_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_is_mem,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_RF_LD, S_RF_OUT, S_DM_REQ, S_DM_LD, S_DM_OUT, S_DONE
  } state_t;

  localparam logic [2:0] LAST_REG = 3'(NUM_REGS - 1);
  localparam bit         HAS_MEM  = (MEM_WORDS > 0);
  localparam int         LAST_MEM = (MEM_WORDS > 0) ? MEM_WORDS - 1 : 0;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_index_q, out_index_d;
  logic                out_is_mem_q, out_is_mem_d;
  logic                out_last_q, out_last_d;

  // State and captured-word registers; the word registers only change in the
  // load states, so they stay stable while a stalled word waits for ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      out_is_mem_q <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      out_is_mem_q <= out_is_mem_d;
      out_last_q   <= out_last_d;
    end
  end

  // Next-state logic: register words take load+present, memory words take
  // request+load+present because memory data arrives a cycle after the strobe.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_index_d  = out_index_q;
    out_is_mem_d = out_is_mem_q;
    out_last_d   = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HALT;
      end
      S_HALT: begin
        if (halt_ack) begin
          idx_d   = '0;
          state_d = S_RF_LD;
        end
      end
      S_RF_LD: begin
        out_data_d   = rf_rd_data;
        out_index_d  = ADDR_W'(idx_q);
        out_is_mem_d = 1'b0;
        out_last_d   = (idx_q == LAST_REG) && !HAS_MEM;
        state_d      = S_RF_OUT;
      end
      S_RF_OUT: begin
        if (out_ready) begin
          if (idx_q < LAST_REG) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_RF_LD;
          end else if (HAS_MEM) begin
            ptr_d   = MEM_BASE;
            cnt_d   = '0;
            state_d = S_DM_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DM_REQ: begin
        state_d = S_DM_LD;
      end
      S_DM_LD: begin
        out_data_d   = dm_rd_data;
        out_index_d  = ptr_q;
        out_is_mem_d = 1'b1;
        out_last_d   = (cnt_q == 32'(LAST_MEM));
        state_d      = S_DM_OUT;
      end
      S_DM_OUT: begin
        if (out_ready) begin
          if (cnt_q < 32'(LAST_MEM)) begin
            ptr_d   = ptr_q + ADDR_W'(1);
            cnt_d   = cnt_q + 32'd1;
            state_d = S_DM_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        out_last_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode straight from the state and captured registers.
  always_comb begin
    halt_req   = (state_q != S_IDLE) && (state_q != S_DONE);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    out_valid  = (state_q == S_RF_OUT) || (state_q == S_DM_OUT);
    dm_rd_en   = (state_q == S_DM_REQ);
    dm_rd_addr = ptr_q;
    rf_rd_addr = idx_q;
    out_data   = out_data_q;
    out_index  = out_index_q;
    out_is_mem = out_is_mem_q;
    out_last   = out_last_q;
  end

endmodule

// File: tb/tb_risc_state_dump.sv
// Directed bench for risc_state_dump: three instances cover a register-only
// dump, a small memory window, and a window that wraps the address space.
module tb_risc_state_dump;

   typedef struct {
      logic        last;
      logic        isMem;
      logic [15:0] idx;
      logic [15:0] data;
      int          cyc;
   } word_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        haltAck;
   logic        outReady;
   logic [2:0]  startV;
   logic [2:0]  haltReq, dmRdEn, outValid, outIsMem, outLast, busy, done;
   logic [2:0]  rfAddr [3];
   logic [15:0] rfData [3];
   logic [15:0] dmAddr [3];
   logic [15:0] dmData [3];
   logic [15:0] outData [3];
   logic [15:0] outIdx [3];

   logic [15:0] regFile [8];
   logic [15:0] mem [0:65535];
   logic [15:0] expReg [8];

   word_t qA[$], qB[$], qC[$];
   int    dmCount [3];
   int    doneCount [3];
   int    doneCyc [3];
   int    lastCyc [3];
   int    cyc = 0;

   int vectorsApplied = 0;
   int miscompares = 0;

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   risc_state_dump #(.NUM_REGS(8), .DATA_W(16), .ADDR_W(16),
                     .MEM_BASE(16'd0), .MEM_WORDS(0)) dutA (
      .clk(clk), .reset(reset), .start(startV[0]), .halt_req(haltReq[0]),
      .halt_ack(haltAck), .rf_rd_addr(rfAddr[0]), .rf_rd_data(rfData[0]),
      .dm_rd_en(dmRdEn[0]), .dm_rd_addr(dmAddr[0]), .dm_rd_data(dmData[0]),
      .out_valid(outValid[0]), .out_ready(outReady), .out_data(outData[0]),
      .out_is_mem(outIsMem[0]), .out_index(outIdx[0]), .out_last(outLast[0]),
      .busy(busy[0]), .done(done[0]));

   risc_state_dump #(.NUM_REGS(8), .DATA_W(16), .ADDR_W(16),
                     .MEM_BASE(16'd10), .MEM_WORDS(2)) dutB (
      .clk(clk), .reset(reset), .start(startV[1]), .halt_req(haltReq[1]),
      .halt_ack(haltAck), .rf_rd_addr(rfAddr[1]), .rf_rd_data(rfData[1]),
      .dm_rd_en(dmRdEn[1]), .dm_rd_addr(dmAddr[1]), .dm_rd_data(dmData[1]),
      .out_valid(outValid[1]), .out_ready(outReady), .out_data(outData[1]),
      .out_is_mem(outIsMem[1]), .out_index(outIdx[1]), .out_last(outLast[1]),
      .busy(busy[1]), .done(done[1]));

   risc_state_dump #(.NUM_REGS(8), .DATA_W(16), .ADDR_W(16),
                     .MEM_BASE(16'hFFFF), .MEM_WORDS(2)) dutC (
      .clk(clk), .reset(reset), .start(startV[2]), .halt_req(haltReq[2]),
      .halt_ack(haltAck), .rf_rd_addr(rfAddr[2]), .rf_rd_data(rfData[2]),
      .dm_rd_en(dmRdEn[2]), .dm_rd_addr(dmAddr[2]), .dm_rd_data(dmData[2]),
      .out_valid(outValid[2]), .out_ready(outReady), .out_data(outData[2]),
      .out_is_mem(outIsMem[2]), .out_index(outIdx[2]), .out_last(outLast[2]),
      .busy(busy[2]), .done(done[2]));

   // Register file model: combinational read for every instance.
   always_comb begin
      for (int i = 0; i < 3; i++) rfData[i] = regFile[rfAddr[i]];
   end

   // Data memory model: read data valid the cycle after the strobe.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) if (dmRdEn[i]) dmData[i] <= mem[dmAddr[i]];
   end

   // Transfer monitor: logs every accepted word plus strobe and done events.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && outValid[0] && outReady) qA.push_back('{outLast[0], outIsMem[0], outIdx[0], outData[0], cyc});
      if (!reset && outValid[1] && outReady) qB.push_back('{outLast[1], outIsMem[1], outIdx[1], outData[1], cyc});
      if (!reset && outValid[2] && outReady) qC.push_back('{outLast[2], outIsMem[2], outIdx[2], outData[2], cyc});
      for (int i = 0; i < 3; i++) begin
         if (!reset && dmRdEn[i]) dmCount[i] <= dmCount[i] + 1;
         if (!reset && done[i]) begin
            doneCount[i] <= doneCount[i] + 1;
            doneCyc[i]   <= cyc;
         end
         if (!reset && outValid[i] && outReady && outLast[i]) lastCyc[i] <= cyc;
      end
   end

   function automatic word_t pick(input int which, input int k);
      word_t w;
      w = '{last: 1'b0, isMem: 1'b0, idx: 16'h0, data: 16'h0, cyc: -1};
      case (which)
         0: if (k < qA.size()) w = qA[k];
         1: if (k < qB.size()) w = qB[k];
         default: if (k < qC.size()) w = qC[k];
      endcase
      return w;
   endfunction

   function automatic int qSize(input int which);
      case (which)
         0: return qA.size();
         1: return qB.size();
         default: return qC.size();
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorsApplied++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkWord(input string tag, input int which, input int k,
                            input logic isMem, input logic [15:0] idx,
                            input logic [15:0] data, input logic last);
      word_t w;
      w = pick(which, k);
      checkOutput(tag, 64'({w.last, w.isMem, w.idx, w.data}), 64'({last, isMem, idx, data}));
   endtask

   task automatic applyStimulus(input int which);
      startV[which] = 1'b1;
      @(negedge clk);
      startV[which] = 1'b0;
   endtask

   // Checks all eight register words of one dump starting at queue index base.
   task automatic checkRegWords(input string tag, input int which, input int base, input logic lastOnR7);
      for (int k = 0; k < 8; k++)
         checkWord($sformatf("%s_reg%0d", tag, k), which, base + k, 1'b0,
                   16'(k), expReg[k], lastOnR7 && (k == 7));
   endtask

   int  baseQ, baseDone, baseDm;
   bit  found;

   initial begin
      reset = 1'b1;
      haltAck = 1'b1;
      outReady = 1'b1;
      startV = 3'b000;
      for (int i = 0; i < 8; i++) regFile[i] = 16'h0;
      regFile[2] = 16'd2;
      regFile[3] = 16'd3;
      regFile[4] = 16'd4;
      for (int i = 0; i < 8; i++) expReg[i] = 16'h0;
      expReg[2] = 16'd2;
      expReg[3] = 16'd3;
      expReg[4] = 16'd4;
      mem[16'd9]    = 16'hDEAD;
      mem[16'd10]   = 16'h0000;
      mem[16'd11]   = 16'h00AB;
      mem[16'd12]   = 16'hBEEF;
      mem[16'hFFFE] = 16'hFFFE;
      mem[16'hFFFF] = 16'h1234;
      mem[16'h0000] = 16'h5678;
      mem[16'h0001] = 16'h0001;

      // Reset values on all three instances.
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("reset_ctl%0d", i),
                     64'({haltReq[i], dmRdEn[i], outValid[i], outLast[i], busy[i], done[i]}), 64'(0));
         checkOutput($sformatf("reset_data%0d", i),
                     64'({outData[i], outIdx[i], rfAddr[i], dmAddr[i]}), 64'(0));
      end
      reset = 1'b0;
      @(negedge clk);

      // Register-only dump with ready and ack tied high.
      baseQ = qSize(0);
      baseDone = doneCount[0];
      applyStimulus(0);
      checkOutput("t1_halt_latency", 64'({haltReq[0], busy[0], outValid[0]}), 64'(3'b110));
      @(negedge clk);
      checkOutput("t1_valid_not_yet", 64'(outValid[0]), 64'(0));
      @(negedge clk);
      checkOutput("t1_first_word", 64'({outValid[0], outIsMem[0], outIdx[0], outData[0]}), 64'({1'b1, 1'b0, 16'd0, 16'd0}));
      repeat (30) @(negedge clk);
      checkOutput("t1_word_count", 64'(qSize(0) - baseQ), 64'(8));
      checkRegWords("t1", 0, baseQ, 1'b1);
      checkOutput("t1_reg_spacing", 64'(pick(0, baseQ + 1).cyc - pick(0, baseQ).cyc), 64'(2));
      checkOutput("t1_done_once", 64'(doneCount[0] - baseDone), 64'(1));
      checkOutput("t1_done_latency", 64'(doneCyc[0] - lastCyc[0]), 64'(1));
      checkOutput("t1_idle_after", 64'({busy[0], haltReq[0], outValid[0], outLast[0]}), 64'(0));

      // Registers followed by a two-word memory window at 10.
      baseQ = qSize(1);
      baseDone = doneCount[1];
      baseDm = dmCount[1];
      applyStimulus(1);
      repeat (45) @(negedge clk);
      checkOutput("t2_word_count", 64'(qSize(1) - baseQ), 64'(10));
      checkRegWords("t2", 1, baseQ, 1'b0);
      checkWord("t2_mem10", 1, baseQ + 8, 1'b1, 16'd10, 16'h0000, 1'b0);
      checkWord("t2_mem11", 1, baseQ + 9, 1'b1, 16'd11, 16'h00AB, 1'b1);
      checkOutput("t2_dm_strobes", 64'(dmCount[1] - baseDm), 64'(2));
      checkOutput("t2_mem_spacing", 64'(pick(1, baseQ + 9).cyc - pick(1, baseQ + 8).cyc), 64'(3));
      checkOutput("t2_done_once", 64'(doneCount[1] - baseDone), 64'(1));

      // Backpressure for five cycles while R3 is on the port.
      baseQ = qSize(1);
      applyStimulus(1);
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         if (outValid[1] && !outIsMem[1] && outIdx[1] == 16'd3) found = 1'b1;
         else @(negedge clk);
      end
      checkOutput("t3_reached_r3", 64'(found), 64'(1));
      outReady = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         checkOutput($sformatf("t3_hold%0d", n),
                     64'({outValid[1], outIsMem[1], outLast[1], outIdx[1], outData[1]}),
                     64'({1'b1, 1'b0, 1'b0, 16'd3, 16'd3}));
      end
      outReady = 1'b1;
      repeat (45) @(negedge clk);
      checkOutput("t3_word_count", 64'(qSize(1) - baseQ), 64'(10));
      checkRegWords("t3", 1, baseQ, 1'b0);
      checkWord("t3_mem11", 1, baseQ + 9, 1'b1, 16'd11, 16'h00AB, 1'b1);

      // Late halt_ack and stray start pulses while busy.
      haltAck = 1'b0;
      baseQ = qSize(0);
      baseDone = doneCount[0];
      applyStimulus(0);
      for (int n = 0; n < 6; n++) begin
         checkOutput($sformatf("t4_wait_ack%0d", n), 64'({haltReq[0], busy[0], outValid[0]}), 64'(3'b110));
         @(negedge clk);
      end
      haltAck = 1'b1;
      @(negedge clk);
      checkOutput("t4_valid_after_1", 64'(outValid[0]), 64'(0));
      @(negedge clk);
      checkOutput("t4_valid_after_2", 64'({outValid[0], outIdx[0]}), 64'({1'b1, 16'd0}));
      haltAck = 1'b0;
      applyStimulus(0);
      @(negedge clk);
      applyStimulus(0);
      repeat (30) @(negedge clk);
      checkOutput("t4_word_count", 64'(qSize(0) - baseQ), 64'(8));
      checkOutput("t4_done_once", 64'(doneCount[0] - baseDone), 64'(1));
      checkOutput("t4_idle_after", 64'({busy[0], haltReq[0]}), 64'(0));
      haltAck = 1'b1;

      // Memory window wrapping from FFFF to 0000.
      baseQ = qSize(2);
      baseDm = dmCount[2];
      applyStimulus(2);
      repeat (45) @(negedge clk);
      checkOutput("t5_word_count", 64'(qSize(2) - baseQ), 64'(10));
      checkWord("t5_memFFFF", 2, baseQ + 8, 1'b1, 16'hFFFF, 16'h1234, 1'b0);
      checkWord("t5_mem0000", 2, baseQ + 9, 1'b1, 16'h0000, 16'h5678, 1'b1);
      checkOutput("t5_dm_strobes", 64'(dmCount[2] - baseDm), 64'(2));

      // Reset while the first memory word is on the port, then a fresh dump.
      baseDone = doneCount[2];
      applyStimulus(2);
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         if (outValid[2] && outIsMem[2]) found = 1'b1;
         else @(negedge clk);
      end
      checkOutput("t6_reached_mem", 64'(found), 64'(1));
      outReady = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("t6_after_reset", 64'({busy[2], haltReq[2], outValid[2], done[2]}), 64'(0));
      reset = 1'b0;
      outReady = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("t6_no_done", 64'(doneCount[2] - baseDone), 64'(0));
      baseQ = qSize(2);
      applyStimulus(2);
      repeat (45) @(negedge clk);
      checkOutput("t6_word_count", 64'(qSize(2) - baseQ), 64'(10));
      checkRegWords("t6", 2, baseQ, 1'b0);
      checkWord("t6_mem0000", 2, baseQ + 9, 1'b1, 16'h0000, 16'h5678, 1'b1);
      checkOutput("t6_done_once", 64'(doneCount[2] - baseDone), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
